// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt controller: register map, id width, bus states.
package gpio_irq_pkg;

    // Width of the interrupt id (0 = none, 1..31 = source index + 1)
    localparam int ID_W = 5;

    // Register offsets (io_addr[5:0])
    localparam logic [5:0] OFF_EN    = 6'h00;
    localparam logic [5:0] OFF_TRIG  = 6'h04;
    localparam logic [5:0] OFF_POL   = 6'h08;
    localparam logic [5:0] OFF_PEND  = 6'h0C;
    localparam logic [5:0] OFF_CLAIM = 6'h10;

    // Bus handshake states: accept in IDLE, pulse io_ready in ACK
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/gpio_irq_sync.sv
// One GPIO line: 2-flop synchronizer plus a history flop for edge detection.
module gpio_irq_sync
    import gpio_irq_pkg::*;
(
    input  logic gpio_clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the pad level and keep the previous synchronized value
    always_ff @(posedge gpio_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: per-line edge/level pending bits, lowest-index
// priority encode, and a two-state register bus with claim support.
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int NUM = 16,
    parameter int DW  = 32
) (
    input  logic            gpio_clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   io_addr,
    input  logic            io_read,
    input  logic            io_write,
    input  logic [DW-1:0]   io_wdata,
    output logic [DW-1:0]   io_rdata,
    output logic            io_ready,
    input  logic [NUM-1:0]  gpio_in,
    output logic            irq,
    output logic [ID_W-1:0] irq_id
);

    logic [NUM-1:0]  lvl, rise, fall;
    logic [NUM-1:0]  en_q, en_d, trig_q, trig_d, pol_q, pol_d, pend_q, pend_d;
    logic [NUM-1:0]  w1c, claim_hit, act;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            irq_q, irq_d;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic [5:0]      addr;
    logic            do_read, do_write;
    bus_state_e      state_q, state_d;

    // Only the low six address bits and NUM data bits carry meaning
    logic unused_bits;
    assign unused_bits = ^{io_addr[DW-1:6], io_wdata[DW-1:NUM]};
    assign addr = io_addr[5:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_line
            gpio_irq_sync u_sync (
                .gpio_clk (gpio_clk),
                .rst_n    (rst_n),
                .pin_i    (gpio_in[gi]),
                .level_o  (lvl[gi]),
                .rise_o   (rise[gi]),
                .fall_o   (fall[gi])
            );

            logic edge_hit;
            // A claim only clears the source currently reported on irq_id
            assign claim_hit[gi] = do_read && (addr == OFF_CLAIM) && (irq_id_q == ID_W'(gi + 1));
            assign edge_hit      = en_q[gi] & (pol_q[gi] ? fall[gi] : rise[gi]);
            // Edge: new edge beats any clear in the same cycle. Level: follows the pin.
            assign pend_d[gi] = trig_q[gi]
                              ? (edge_hit | (pend_q[gi] & ~(w1c[gi] | claim_hit[gi])))
                              : ((lvl[gi] ^ pol_q[gi]) & en_q[gi]);
        end
    endgenerate

    // Bus FSM state register
    always_ff @(posedge gpio_clk or negedge rst_n) begin
        if (!rst_n) state_q <= BUS_IDLE;
        else        state_q <= state_d;
    end

    // Bus FSM next state: accept in IDLE, always return from ACK
    always_comb begin
        state_d = BUS_IDLE;
        if (state_q == BUS_IDLE && (io_read || io_write)) state_d = BUS_ACK;
    end

    // Bus FSM outputs: a write takes precedence over a simultaneous read
    always_comb begin
        do_write = 1'b0;
        do_read  = 1'b0;
        if (state_q == BUS_IDLE) begin
            do_write = io_write;
            do_read  = io_read & ~io_write;
        end
    end
    assign io_ready = (state_q == BUS_ACK);

    // Register writes and the write-1-to-clear mask for PEND
    always_comb begin
        en_d   = en_q;
        trig_d = trig_q;
        pol_d  = pol_q;
        w1c    = '0;
        if (do_write) begin
            case (addr)
                OFF_EN:   en_d   = io_wdata[NUM-1:0];
                OFF_TRIG: trig_d = io_wdata[NUM-1:0];
                OFF_POL:  pol_d  = io_wdata[NUM-1:0];
                OFF_PEND: w1c    = io_wdata[NUM-1:0];
                default:  ;
            endcase
        end
    end

    // Read mux; the captured value is held until the next accepted read
    always_comb begin
        rdata_d = rdata_q;
        if (do_read) begin
            rdata_d = '0;
            case (addr)
                OFF_EN:    rdata_d[NUM-1:0]  = en_q;
                OFF_TRIG:  rdata_d[NUM-1:0]  = trig_q;
                OFF_POL:   rdata_d[NUM-1:0]  = pol_q;
                OFF_PEND:  rdata_d[NUM-1:0]  = pend_q;
                OFF_CLAIM: rdata_d[ID_W-1:0] = irq_id_q;
                default:   ;
            endcase
        end
    end

    // Lowest-index active source wins; id is index + 1 so 0 means none
    always_comb begin
        act      = pend_q & en_q;
        irq_d    = |act;
        irq_id_d = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (act[i]) irq_id_d = ID_W'(i + 1);
        end
    end

    // Configuration, pending, read data and interrupt output registers
    always_ff @(posedge gpio_clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= '0;
            trig_q   <= '0;
            pol_q    <= '0;
            pend_q   <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            en_q     <= en_d;
            trig_q   <= trig_d;
            pol_q    <= pol_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign io_rdata = rdata_q;
    assign irq      = irq_q;
    assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl with hand-computed expectations.
module tb_gpio_irq_ctrl;

    localparam int NUM = 16;
    localparam int DW  = 32;

    logic            gpio_clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   io_addr;
    logic            io_read;
    logic            io_write;
    logic [DW-1:0]   io_wdata;
    logic [DW-1:0]   io_rdata;
    logic            io_ready;
    logic [NUM-1:0]  gpio_in;
    logic            irq;
    logic [4:0]      irq_id;

    int err_cnt = 0;
    int chk_cnt = 0;

    gpio_irq_ctrl #(.NUM(NUM), .DW(DW)) dut (
        .gpio_clk (gpio_clk),
        .rst_n    (rst_n),
        .io_addr  (io_addr),
        .io_read  (io_read),
        .io_write (io_write),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .io_ready (io_ready),
        .gpio_in  (gpio_in),
        .irq      (irq),
        .irq_id   (irq_id)
    );

    always #5 gpio_clk = ~gpio_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge gpio_clk);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        logic seen;
        seen     = 1'b0;
        io_addr  = {26'b0, a};
        io_wdata = d;
        io_write = 1'b1;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick(1);
            if (io_ready) seen = 1'b1;
        end
        io_write = 1'b0;
        check("wr_ready", {31'b0, seen}, 32'd1);
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        logic seen;
        seen    = 1'b0;
        d       = '0;
        io_addr = {26'b0, a};
        io_read = 1'b1;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick(1);
            if (io_ready) begin
                seen = 1'b1;
                d    = io_rdata;
            end
        end
        io_read = 1'b0;
        check("rd_ready", {31'b0, seen}, 32'd1);
    endtask

    logic [31:0] rd;
    int          pulses;

    initial begin
        rst_n    = 1'b0;
        io_read  = 1'b0;
        io_write = 1'b0;
        io_addr  = '0;
        io_wdata = '0;
        gpio_in  = '0;
        #12;
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_irq_id", {27'b0, irq_id}, 32'd0);
        check("rst_ready", {31'b0, io_ready}, 32'd0);
        check("rst_rdata", io_rdata, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        bus_read(6'h00, rd);  check("en_reset", rd, 32'h0);
        bus_read(6'h0C, rd);  check("pend_reset", rd, 32'h0);

        // Edge source on pin 0
        bus_write(6'h00, 32'h0005);
        bus_write(6'h04, 32'h0001);
        bus_read(6'h00, rd);  check("en_rb", rd, 32'h0005);
        bus_read(6'h04, rd);  check("trig_rb", rd, 32'h0001);
        gpio_in[0] = 1'b1;
        tick(4);
        check("edge_irq", {31'b0, irq}, 32'd1);
        check("edge_irq_id", {27'b0, irq_id}, 32'd1);
        bus_read(6'h0C, rd);  check("edge_pend", rd, 32'h0001);
        bus_write(6'h0C, 32'h0001);
        tick(2);
        check("w1c_irq", {31'b0, irq}, 32'd0);
        check("w1c_irq_id", {27'b0, irq_id}, 32'd0);

        // Level source on pin 2
        gpio_in[2] = 1'b1;
        tick(4);
        check("lvl_irq", {31'b0, irq}, 32'd1);
        check("lvl_irq_id", {27'b0, irq_id}, 32'd3);
        bus_write(6'h0C, 32'h0004);
        bus_read(6'h0C, rd);  check("lvl_w1c_pend", rd, 32'h0004);
        gpio_in[2] = 1'b0;
        tick(4);
        check("lvl_rel_irq", {31'b0, irq}, 32'd0);
        check("lvl_rel_irq_id", {27'b0, irq_id}, 32'd0);
        bus_read(6'h0C, rd);  check("lvl_rel_pend", rd, 32'h0);

        // Claim: edge source cleared, level source kept
        gpio_in[0] = 1'b0;
        tick(4);
        gpio_in[0] = 1'b1;
        gpio_in[2] = 1'b1;
        tick(4);
        bus_read(6'h0C, rd);  check("claim_pre_pend", rd, 32'h0005);
        bus_read(6'h10, rd);  check("claim1", rd, 32'd1);
        bus_read(6'h10, rd);  check("claim2", rd, 32'd3);
        bus_read(6'h0C, rd);  check("claim_post_pend", rd, 32'h0004);

        // Unmapped offsets
        bus_write(6'h14, 32'hFFFF);
        bus_read(6'h20, rd);  check("unmapped_rd", rd, 32'h0);

        // Rising edge coincident with W1C of the same bit
        gpio_in[0] = 1'b0;
        tick(4);
        gpio_in[0] = 1'b1;
        tick(2);
        bus_write(6'h0C, 32'h0001);
        bus_read(6'h0C, rd);  check("set_wins_pend", rd, 32'h0005);
        check("set_wins_irq_id", {27'b0, irq_id}, 32'd1);

        // Read and write together: write wins, read data untouched
        io_addr  = 32'h0;
        io_wdata = 32'hFFFF;
        io_read  = 1'b1;
        io_write = 1'b1;
        pulses   = 0;
        for (int k = 0; k < 2; k++) begin
            tick(1);
            if (io_ready) pulses++;
        end
        io_read  = 1'b0;
        io_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            if (io_ready) pulses++;
        end
        check("rw_pulses", pulses, 32'd1);
        check("rw_rdata_held", io_rdata, 32'h0005);
        bus_read(6'h00, rd);  check("rw_en", rd, 32'hFFFF);

        // Reset during a pending read of PEND
        io_addr = 32'h0C;
        io_read = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_irq", {31'b0, irq}, 32'd0);
        check("arst_irq_id", {27'b0, irq_id}, 32'd0);
        check("arst_ready", {31'b0, io_ready}, 32'd0);
        check("arst_rdata", io_rdata, 32'd0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            if (io_ready) pulses++;
        end
        io_read = 1'b0;
        check("arst_no_ready", pulses, 32'd0);
        rst_n = 1'b1;
        tick(1);
        bus_read(6'h0C, rd);  check("reissue_pend", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
